mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl
//
// Memory BIST controller running March C- over a single-port SRAM:
//   M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0),
//   M5 up(r0)
// One SRAM operation per cycle, 10N operations per run. Read data is compared
// RD_LAT cycles after the read command using a pipeline of expected values.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_bist      start request (level, honoured only when idle)
//   abort           terminate a run in progress (RUN or DRAIN)
//   bg_sel          data background: 0 solid, 1 checkerboard (latched at start)
//   bist_busy       run in progress, including drain
//   bist_done       sticky completion flag, cleared by the next start
//   bist_pass       no mismatch in the last completed run
//   fail_cnt        saturating mismatch counter
//   fail_addr/elem  address and march element of the first mismatch
//   csb0, web0      SRAM chip select / write enable, active-low, registered
//   addr0, din0     SRAM address / write data, registered
//   dout0           SRAM read data
// ---------------------------------------------------------------------------
module mbist_march_ctrl #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_bist,
    input  logic                  abort,
    input  logic                  bg_sel,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_pass,
    output logic [FCNT_WIDTH-1:0] fail_cnt,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int unsigned PipeLen = RD_LAT + 1;
    localparam logic [ADDR_WIDTH:0]   AddrTop   = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0]   AddrOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [FCNT_WIDTH-1:0] FcntOne   = {{(FCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2:0]            DrainLast = 3'(RD_LAT - 1);
    localparam logic [DATA_WIDTH-1:0] CkbBase   = {(DATA_WIDTH/2){2'b01}};

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    // Sequencer: address counter carries one extra bit so that both the
    // up-count past N-1 and the down-count past 0 show up as bit ADDR_WIDTH.
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH:0]   addr_q, addr_d;
    logic                  phase_q, phase_d;
    logic                  bg_q, bg_d;
    logic [2:0]            drain_cnt_q, drain_cnt_d;

    // SRAM port registers
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;

    // Result registers
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [2:0]            felem_q, felem_d;

    // Expected-data pipeline; stage 0 is aligned with the port registers.
    logic [RD_LAT:0]       pv_q, pv_d;
    logic [DATA_WIDTH-1:0] pexp_q  [PipeLen];
    logic [DATA_WIDTH-1:0] pexp_d  [PipeLen];
    logic [ADDR_WIDTH-1:0] paddr_q [PipeLen];
    logic [ADDR_WIDTH-1:0] paddr_d [PipeLen];
    logic [2:0]            pelem_q [PipeLen];
    logic [2:0]            pelem_d [PipeLen];

    // Control decode
    logic start_take, abort_take, issue_op, finish;

    // Element decode
    logic el_down, el_rd, el_rval, el_wr, el_wval;

    // Current operation
    logic                  op_rd, addr_last_op, elem_end, run_end;
    logic [ADDR_WIDTH:0]   addr_nxt, next_start;
    logic [DATA_WIDTH-1:0] d0, pat;
    logic                  mismatch;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_bist) state_d = StRun;
            StRun: begin
                if (abort)        state_d = StIdle;
                else if (run_end) state_d = StDrain;
            end
            StDrain: begin
                if (abort)                           state_d = StIdle;
                else if (drain_cnt_q == DrainLast)   state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bist_busy  = (state_q != StIdle);
        start_take = (state_q == StIdle) && start_bist;
        abort_take = ((state_q == StRun) || (state_q == StDrain)) && abort;
        issue_op   = (state_q == StRun) && !abort;
        finish     = (state_q == StDone);
    end

    // -----------------------------------------------------------------------
    // March element decode
    // -----------------------------------------------------------------------
    always_comb begin
        el_down = 1'b0;
        el_rd   = 1'b0;
        el_rval = 1'b0;
        el_wr   = 1'b0;
        el_wval = 1'b0;
        unique case (elem_q)
            3'd0: begin el_wr = 1'b1; end
            3'd1: begin el_rd = 1'b1; el_wr = 1'b1; el_wval = 1'b1; end
            3'd2: begin el_rd = 1'b1; el_rval = 1'b1; el_wr = 1'b1; end
            3'd3: begin el_down = 1'b1; el_rd = 1'b1; el_wr = 1'b1; el_wval = 1'b1; end
            3'd4: begin el_down = 1'b1; el_rd = 1'b1; el_rval = 1'b1; el_wr = 1'b1; end
            default: begin el_rd = 1'b1; end
        endcase
    end

    // -----------------------------------------------------------------------
    // Current operation and sequencing
    // -----------------------------------------------------------------------
    always_comb begin
        op_rd        = el_rd && !phase_q;
        // Last op on this address unless a write still follows the read.
        addr_last_op = !(op_rd && el_wr);
        addr_nxt     = el_down ? (addr_q - AddrOne) : (addr_q + AddrOne);
        elem_end     = addr_last_op && addr_nxt[ADDR_WIDTH];
        run_end      = elem_end && (elem_q == 3'd5);
        // Elements 3 and 4 run downwards.
        next_start   = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? AddrTop : '0;

        d0  = bg_q ? (CkbBase ^ {DATA_WIDTH{addr_q[0]}}) : '0;
        pat = (op_rd ? el_rval : el_wval) ? ~d0 : d0;

        // Exact 4-state compare so X/Z read data is flagged.
        mismatch = pv_q[RD_LAT] && (dout0 !== pexp_q[RD_LAT]);
    end

    // -----------------------------------------------------------------------
    // Datapath next state
    // -----------------------------------------------------------------------
    always_comb begin
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        bg_d        = bg_q;
        drain_cnt_d = drain_cnt_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        addr0_d     = addr0_q;
        din0_d      = din0_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fcnt_d      = fcnt_q;
        faddr_d     = faddr_q;
        felem_d     = felem_q;

        pv_d       = {pv_q[RD_LAT-1:0], 1'b0};
        pexp_d[0]  = pexp_q[0];
        paddr_d[0] = paddr_q[0];
        pelem_d[0] = pelem_q[0];
        for (int i = 1; i < PipeLen; i++) begin
            pexp_d[i]  = pexp_q[i-1];
            paddr_d[i] = paddr_q[i-1];
            pelem_d[i] = pelem_q[i-1];
        end

        if (mismatch && !abort_take) begin
            pass_d = 1'b0;
            if (!(&fcnt_q)) fcnt_d = fcnt_q + FcntOne;
            // Counter never wraps, so zero means no earlier mismatch this run.
            if (fcnt_q == '0) begin
                faddr_d = paddr_q[RD_LAT];
                felem_d = pelem_q[RD_LAT];
            end
        end

        if (issue_op) begin
            csb_d      = 1'b0;
            web_d      = op_rd;
            addr0_d    = addr_q[ADDR_WIDTH-1:0];
            if (!op_rd) din0_d = pat;
            pv_d[0]    = op_rd;
            pexp_d[0]  = pat;
            paddr_d[0] = addr_q[ADDR_WIDTH-1:0];
            pelem_d[0] = elem_q;

            if (addr_last_op) begin
                phase_d = 1'b0;
                if (elem_end) begin
                    elem_d = elem_q + 3'd1;
                    addr_d = next_start;
                end else begin
                    addr_d = addr_nxt;
                end
            end else begin
                phase_d = 1'b1;
            end
        end

        if (state_q == StRun)        drain_cnt_d = '0;
        else if (state_q == StDrain) drain_cnt_d = drain_cnt_q + 3'd1;

        if (finish) done_d = 1'b1;

        if (abort_take) begin
            pv_d   = '0;
            pass_d = 1'b0;
        end

        if (start_take) begin
            elem_d  = '0;
            addr_d  = '0;
            phase_d = 1'b0;
            bg_d    = bg_sel;
            done_d  = 1'b0;
            pass_d  = 1'b1;
            fcnt_d  = '0;
            faddr_d = '0;
            felem_d = '0;
            pv_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q      <= '0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            bg_q        <= 1'b0;
            drain_cnt_q <= '0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            addr0_q     <= '0;
            din0_q      <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fcnt_q      <= '0;
            faddr_q     <= '0;
            felem_q     <= '0;
            pv_q        <= '0;
            for (int i = 0; i < PipeLen; i++) begin
                pexp_q[i]  <= '0;
                paddr_q[i] <= '0;
                pelem_q[i] <= '0;
            end
        end else begin
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            bg_q        <= bg_d;
            drain_cnt_q <= drain_cnt_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fcnt_q      <= fcnt_d;
            faddr_q     <= faddr_d;
            felem_q     <= felem_d;
            pv_q        <= pv_d;
            for (int i = 0; i < PipeLen; i++) begin
                pexp_q[i]  <= pexp_d[i];
                paddr_q[i] <= paddr_d[i];
                pelem_q[i] <= pelem_d[i];
            end
        end
    end

    assign csb0      = csb_q;
    assign web0      = web_q;
    assign addr0     = addr0_q;
    assign din0      = din0_q;
    assign bist_done = done_q;
    assign bist_pass = pass_q;
    assign fail_cnt  = fcnt_q;
    assign fail_addr = faddr_q;
    assign fail_elem = felem_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
module tb_mbist_march_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_bist = 1'b0;
    logic abort = 1'b0;
    logic bg_sel = 1'b0;

    logic        busy1, done1, pass1, csb1, web1;
    logic [15:0] fcnt1;
    logic [3:0]  faddr1, addr1;
    logic [2:0]  felem1;
    logic [7:0]  din1, dout1;

    logic        busy3, done3, pass3, csb3, web3;
    logic [15:0] fcnt3;
    logic [3:0]  faddr3, addr3;
    logic [2:0]  felem3;
    logic [7:0]  din3, dout3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1), .FCNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_bist(start_bist), .abort(abort), .bg_sel(bg_sel),
        .bist_busy(busy1), .bist_done(done1), .bist_pass(pass1), .fail_cnt(fcnt1),
        .fail_addr(faddr1), .fail_elem(felem1), .csb0(csb1), .web0(web1), .addr0(addr1),
        .din0(din1), .dout0(dout1)
    );

    mbist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(3), .FCNT_WIDTH(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_bist(start_bist), .abort(abort), .bg_sel(bg_sel),
        .bist_busy(busy3), .bist_done(done3), .bist_pass(pass3), .fail_cnt(fcnt3),
        .fail_addr(faddr3), .fail_elem(felem3), .csb0(csb3), .web0(web3), .addr0(addr3),
        .din0(din3), .dout0(dout3)
    );

    // Fault injection: one bit of one word reads as a constant.
    logic flt_en = 1'b0;
    int   flt_addr = 0;
    int   flt_bit = 0;
    logic flt_val = 1'b0;

    function automatic logic [7:0] faulty(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (flt_en && (int'(a) == flt_addr)) r[flt_bit] = flt_val;
        return r;
    endfunction

    // SRAM models: 1-cycle and 3-cycle read latency
    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic [7:0] d3   [3];

    always @(posedge clk) begin
        if (!csb1 && !web1) mem1[addr1] <= din1;
        if (!csb1 && web1)  dout1 <= faulty(addr1, mem1[addr1]);
    end

    always @(posedge clk) begin
        if (!csb3 && !web3) mem3[addr3] <= din3;
        d3[0] <= (!csb3 && web3) ? faulty(addr3, mem3[addr3]) : 8'h00;
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign dout3 = d3[2];

    // Monitor selection
    logic       sel3 = 1'b0;
    logic       m_csb, m_web, m_done, m_pass;
    logic [3:0] m_addr;
    logic [7:0] m_din;
    always_comb begin
        m_csb  = sel3 ? csb3  : csb1;
        m_web  = sel3 ? web3  : web1;
        m_done = sel3 ? done3 : done1;
        m_pass = sel3 ? pass3 : pass1;
        m_addr = sel3 ? addr3 : addr1;
        m_din  = sel3 ? din3  : din1;
    end

    typedef struct { bit wr; int addr; int data; int elem; } op_t;
    op_t exp_q[$];
    op_t obs_q[$];

    function automatic void push_exp(input bit wr, input int a, input int d, input int e);
        op_t o;
        o.wr = wr; o.addr = a; o.data = d; o.elem = e;
        exp_q.push_back(o);
    endfunction

    // March C- operation list written straight from the algorithm.
    function automatic void build_expected(input bit bg);
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                int a;
                int z;
                int o;
                a = (e == 3 || e == 4) ? (N - 1 - i) : i;
                z = bg ? ((a % 2 == 1) ? 'hAA : 'h55) : 0;
                o = z ^ 'hFF;
                case (e)
                    0: push_exp(1, a, z, e);
                    1: begin push_exp(0, a, z, e); push_exp(1, a, o, e); end
                    2: begin push_exp(0, a, o, e); push_exp(1, a, z, e); end
                    3: begin push_exp(0, a, z, e); push_exp(1, a, o, e); end
                    4: begin push_exp(0, a, o, e); push_exp(1, a, z, e); end
                    default: push_exp(0, a, z, e);
                endcase
            end
        end
    endfunction

    // Behavioural run of the op list against a faulty memory.
    function automatic void model_faults(output int cnt, output int fa, output int fe);
        int mem [16];
        logic [7:0] rv;
        cnt = 0; fa = 0; fe = 0;
        for (int i = 0; i < 16; i++) mem[i] = 0;
        foreach (exp_q[i]) begin
            if (exp_q[i].wr) begin
                mem[exp_q[i].addr] = exp_q[i].data;
            end else begin
                rv = faulty(4'(exp_q[i].addr), 8'(mem[exp_q[i].addr]));
                if (int'(rv) != exp_q[i].data) begin
                    if (cnt == 0) begin
                        fa = exp_q[i].addr;
                        fe = exp_q[i].elem;
                    end
                    cnt++;
                end
            end
        end
    endfunction

    function automatic int seq_bad();
        int bad;
        bad = 0;
        if (obs_q.size() != exp_q.size()) return 1000;
        foreach (exp_q[i]) begin
            if (obs_q[i].wr != exp_q[i].wr || obs_q[i].addr != exp_q[i].addr ||
                (exp_q[i].wr && obs_q[i].data != exp_q[i].data)) bad++;
        end
        return bad;
    endfunction

    // Start pulse sampled at the next rising edge; bg_sel is flipped
    // afterwards so the run depends on the latched value only.
    task automatic kick(input bit bg);
        @(negedge clk);
        bg_sel = bg;
        start_bist = 1'b1;
        @(posedge clk);
        #1;
        start_bist = 1'b0;
        bg_sel = ~bg;
    endtask

    task automatic collect(input int budget, output int done_cyc, output int first_cyc);
        op_t o;
        obs_q.delete();
        done_cyc = -1;
        first_cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (!m_csb) begin
                o.wr = !m_web; o.addr = int'(m_addr); o.data = int'(m_din); o.elem = 0;
                obs_q.push_back(o);
                if (first_cyc < 0) first_cyc = c;
            end
            if (m_done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    logic [39:0] rst_vec;
    assign rst_vec = {1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 3'h0};

    task automatic test_reset();
        logic [39:0] v1, v3;
        #12;
        v1 = {csb1, web1, addr1, din1, busy1, done1, pass1, fcnt1, faddr1, felem1};
        v3 = {csb3, web3, addr3, din3, busy3, done3, pass3, fcnt3, faddr3, felem3};
        checks++;
        if (v1 !== rst_vec) begin errors++; $display("FAIL reset_outputs: got %h expected %h", v1, rst_vec); end
        checks++;
        if (v3 !== rst_vec) begin errors++; $display("FAIL reset_outputs_lat3: got %h expected %h", v3, rst_vec); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy1, csb1} !== 2'b01) begin errors++; $display("FAIL idle_after_reset: got %b expected 01", {busy1, csb1}); end
    endtask

    task automatic test_solid();
        int dc, fc, bad;
        sel3 = 1'b0; flt_en = 1'b0;
        build_expected(1'b0);
        kick(1'b0);
        collect(400, dc, fc);
        bad = seq_bad();
        checks++;
        if (obs_q.size() != 10 * N) begin errors++; $display("FAIL solid_op_count: got %0d expected %0d", obs_q.size(), 10 * N); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL solid_op_order: got %0d bad ops expected 0", bad); end
        checks++;
        if (dc != 10 * N + 2) begin errors++; $display("FAIL solid_done_cycle: got %0d expected %0d", dc, 10 * N + 2); end
        checks++;
        if (fc != 1) begin errors++; $display("FAIL solid_first_op_cycle: got %0d expected 1", fc); end
        checks++;
        if ({pass1, fcnt1, busy1} !== {1'b1, 16'h0, 1'b0}) begin
            errors++; $display("FAIL solid_result: got pass=%b cnt=%0d busy=%b expected 1 0 0", pass1, fcnt1, busy1);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done1 !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b expected 1", done1); end
    endtask

    task automatic test_checker();
        int dc, fc, bad;
        sel3 = 1'b0; flt_en = 1'b0;
        build_expected(1'b1);
        kick(1'b1);
        collect(400, dc, fc);
        bad = seq_bad();
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ckb_op_order: got %0d bad ops expected 0", bad); end
        checks++;
        if (obs_q.size() < 2 || obs_q[0].data != 'h55 || obs_q[1].data != 'hAA) begin
            errors++; $display("FAIL ckb_m0_data: got %0d ops, first data %0h expected 55/AA", obs_q.size(),
                               (obs_q.size() > 0) ? obs_q[0].data : -1);
        end
        checks++;
        if (dc != 10 * N + 2 || pass1 !== 1'b1) begin
            errors++; $display("FAIL ckb_done_pass: got cycle %0d pass %b expected %0d 1", dc, pass1, 10 * N + 2);
        end
    endtask

    task automatic test_stuck();
        int dc, fc, cnt, fa, fe;
        sel3 = 1'b0;
        flt_en = 1'b1; flt_addr = 5; flt_bit = 3; flt_val = 1'b1;
        build_expected(1'b0);
        model_faults(cnt, fa, fe);
        kick(1'b0);
        collect(400, dc, fc);
        checks++;
        if (pass1 !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b expected 0", pass1); end
        checks++;
        if (int'(fcnt1) != cnt) begin errors++; $display("FAIL stuck_fail_cnt: got %0d expected %0d", fcnt1, cnt); end
        checks++;
        if (int'(faddr1) != fa || int'(felem1) != fe) begin
            errors++; $display("FAIL stuck_first: got addr %0d elem %0d expected %0d %0d", faddr1, felem1, fa, fe);
        end
        checks++;
        if (dc != 10 * N + 2) begin errors++; $display("FAIL stuck_done_cycle: got %0d expected %0d", dc, 10 * N + 2); end
        flt_en = 1'b0;
    endtask

    task automatic test_random_faults();
        int dc, fc, cnt, fa, fe;
        bit bg;
        sel3 = 1'b0;
        repeat (4) begin
            bg = 1'($urandom_range(0, 1));
            flt_en = 1'b1;
            flt_addr = $urandom_range(0, 15);
            flt_bit = $urandom_range(0, 7);
            flt_val = 1'($urandom_range(0, 1));
            build_expected(bg);
            model_faults(cnt, fa, fe);
            kick(bg);
            collect(400, dc, fc);
            checks++;
            if (pass1 !== (cnt == 0) || int'(fcnt1) != cnt || int'(faddr1) != fa || int'(felem1) != fe) begin
                errors++;
                $display("FAIL rand_fault a%0d b%0d v%0d bg%0d: got pass %b cnt %0d addr %0d elem %0d expected %0d %0d %0d %0d",
                         flt_addr, flt_bit, flt_val, bg, pass1, fcnt1, faddr1, felem1, (cnt == 0), cnt, fa, fe);
            end
        end
        flt_en = 1'b0;
    endtask

    task automatic test_rdlat3();
        int dc, fc, bad, cnt, fa, fe;
        sel3 = 1'b1; flt_en = 1'b0;
        build_expected(1'b0);
        kick(1'b0);
        collect(400, dc, fc);
        bad = seq_bad();
        checks++;
        if (dc != 10 * N + 4) begin errors++; $display("FAIL lat3_done_cycle: got %0d expected %0d", dc, 10 * N + 4); end
        checks++;
        if (pass3 !== 1'b1 || bad != 0) begin errors++; $display("FAIL lat3_pass: got pass %b bad %0d expected 1 0", pass3, bad); end
        flt_en = 1'b1;
        flt_addr = $urandom_range(0, 15); flt_bit = $urandom_range(0, 7); flt_val = 1'($urandom_range(0, 1));
        build_expected(1'b1);
        model_faults(cnt, fa, fe);
        kick(1'b1);
        collect(400, dc, fc);
        checks++;
        if (int'(fcnt3) != cnt || int'(faddr3) != fa || int'(felem3) != fe || pass3 !== (cnt == 0)) begin
            errors++; $display("FAIL lat3_fault: got cnt %0d addr %0d elem %0d expected %0d %0d %0d", fcnt3, faddr3, felem3, cnt, fa, fe);
        end
        flt_en = 1'b0;
        sel3 = 1'b0;
    endtask

    task automatic test_abort();
        int dc, fc, acc, ac;
        sel3 = 1'b0; flt_en = 1'b0;
        kick(1'b0);
        for (int c = 1; c < 50; c++) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if ({csb1, busy1, done1, pass1} !== 4'b1000) begin
            errors++; $display("FAIL abort_c50: got csb/busy/done/pass %b expected 1000", {csb1, busy1, done1, pass1});
        end
        acc = 0;
        repeat (6) begin @(posedge clk); #1; if (!csb1 || done1) acc++; end
        checks++;
        if (acc != 0) begin errors++; $display("FAIL abort_quiet: got %0d accesses expected 0", acc); end

        // Start and abort together in idle: start wins and runs to a pass.
        build_expected(1'b0);
        @(negedge clk);
        bg_sel = 1'b0; start_bist = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start_bist = 1'b0; abort = 1'b0;
        collect(400, dc, fc);
        checks++;
        if (dc != 10 * N + 2 || pass1 !== 1'b1 || seq_bad() != 0) begin
            errors++; $display("FAIL abort_then_run: got done %0d pass %b expected %0d 1", dc, pass1, 10 * N + 2);
        end

        // Abort while idle leaves the result untouched.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if ({done1, pass1, busy1} !== 3'b110) begin
            errors++; $display("FAIL abort_idle: got done/pass/busy %b expected 110", {done1, pass1, busy1});
        end

        // Abort in drain discards the run.
        kick(1'b0);
        for (int c = 1; c <= 10 * N; c++) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy1, done1, pass1} !== 3'b000) begin
            errors++; $display("FAIL abort_drain: got busy/done/pass %b expected 000", {busy1, done1, pass1});
        end

        // Aborts at random points of the run.
        repeat (2) begin
            ac = $urandom_range(2, 158);
            kick(1'b0);
            for (int c = 1; c < ac; c++) begin @(posedge clk); #1; end
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            checks++;
            if ({csb1, busy1, done1, pass1} !== 4'b1000) begin
                errors++; $display("FAIL abort_rand c%0d: got csb/busy/done/pass %b expected 1000", ac, {csb1, busy1, done1, pass1});
            end
        end
    endtask

    task automatic test_start_ignored();
        int dc;
        sel3 = 1'b0; flt_en = 1'b0;
        kick(1'b0);
        dc = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (c == 20) start_bist = 1'b1;
            if (c == 40) start_bist = 1'b0;
            if (done1) begin dc = c; break; end
        end
        checks++;
        if (dc != 10 * N + 2 || pass1 !== 1'b1) begin
            errors++; $display("FAIL start_in_run: got done %0d pass %b expected %0d 1", dc, pass1, 10 * N + 2);
        end

        // Start and abort together while running: abort wins.
        kick(1'b0);
        for (int c = 1; c < 30; c++) begin @(posedge clk); #1; end
        start_bist = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start_bist = 1'b0; abort = 1'b0;
        checks++;
        if ({busy1, done1, csb1} !== 3'b001) begin
            errors++; $display("FAIL abort_beats_start: got busy/done/csb %b expected 001", {busy1, done1, csb1});
        end
    endtask

    task automatic test_reset_midrun();
        int dc, fc, acc;
        logic [39:0] v1, v3;
        sel3 = 1'b0; flt_en = 1'b0;
        kick(1'b0);
        for (int c = 1; c < 30; c++) begin @(posedge clk); #1; end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        v1 = {csb1, web1, addr1, din1, busy1, done1, pass1, fcnt1, faddr1, felem1};
        v3 = {csb3, web3, addr3, din3, busy3, done3, pass3, fcnt3, faddr3, felem3};
        checks++;
        if (v1 !== rst_vec) begin errors++; $display("FAIL reset_midrun: got %h expected %h", v1, rst_vec); end
        checks++;
        if (v3 !== rst_vec) begin errors++; $display("FAIL reset_midrun_lat3: got %h expected %h", v3, rst_vec); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 0;
        repeat (20) begin @(posedge clk); #1; if (!csb1 || busy1) acc++; end
        checks++;
        if (acc != 0) begin errors++; $display("FAIL reset_no_resume: got %0d active cycles expected 0", acc); end
        build_expected(1'b0);
        kick(1'b0);
        collect(400, dc, fc);
        checks++;
        if (dc != 10 * N + 2 || pass1 !== 1'b1 || seq_bad() != 0) begin
            errors++; $display("FAIL reset_rerun: got done %0d pass %b expected %0d 1", dc, pass1, 10 * N + 2);
        end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_checker();
        test_stuck();
        test_random_faults();
        test_rdlat3();
        test_abort();
        test_start_ignored();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
